// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (read and write side).
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;
  localparam int unsigned FN_W           = 32;

  // Width-agnostic: operands narrower than FN_W are zero-extended by the caller.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = g;
    for (int i = int'(FN_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, MSB-down XOR prefix chain.
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = gray;
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain pointer and status controller for the dual-clock FIFO.
module async_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  rd_inc,
  input  logic                  clr_underflow,
  input  logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] bin_ptr;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] level_next;
  logic          rd_accept;
  logic          empty_next;
  logic          aempty_next;
  logic          underflow_next;

  fifo_gray2bin #(.W(PW)) u_wr_g2b (
    .gray (gray_wr_ptr),
    .bin  (wr_bin)
  );

  // Empty compares against the synchronised Gray pointer so it can never deassert early.
  always_comb begin
    rd_accept      = rd_inc & ~rd_empty;
    bin_next       = bin_ptr + PW'(rd_accept);
    gray_next      = PW'(bin2gray(FN_W'(bin_next)));
    level_next     = wr_bin - bin_next;
    empty_next     = (gray_next == gray_wr_ptr);
    aempty_next    = (level_next <= PW'(AEMPTY_THRESH));
    underflow_next = (rd_inc & rd_empty) | (rd_underflow & ~clr_underflow);
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      bin_ptr         <= '0;
      gray_rd_ptr     <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_level        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      bin_ptr         <= bin_next;
      gray_rd_ptr     <= gray_next;
      rd_empty        <= empty_next;
      rd_almost_empty <= aempty_next;
      rd_level        <= level_next;
      rd_underflow    <= underflow_next;
    end
  end

  assign rd_addr = bin_ptr[ADDR_WIDTH-1:0];

endmodule
